pdp_mem_arb: RTL and testbench
==============================

Name: pdp_mem_arb

Overview:
Single-port memory arbiter between the PDP-8 request sources (instr_decode fetch port, instr_exec read and write ports) and one pipelined single-port memory macro. Each cycle it grants at most one request by fixed priority. It tracks in-flight reads in a tag pipeline and steers returned data back to the originating requester. It replaces direct three-port memory access so that a realistic single-port RAM can back the pipeline.

Parameters:
ADDR_WIDTH, 12, word address width (4K-word PDP-8 field)
DATA_WIDTH, 12, word width
RD_LATENCY, 2, cycles from memory read issue to mem_rvld; legal range 1..4
STARVE_LIMIT, 4, consecutive fetch losses before a forced fetch grant (optional feature only)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
ifu_rd_req  in  1  fetch read request; held until granted
ifu_rd_addr  in  ADDR_WIDTH  fetch address
ifu_rd_gnt  out  1  fetch request accepted this cycle
ifu_rd_vld  out  1  fetch data valid pulse
ifu_rd_data  out  DATA_WIDTH  fetch data
exec_rd_req  in  1  exec read request; held until granted
exec_rd_addr  in  ADDR_WIDTH  exec read address
exec_rd_gnt  out  1  exec read accepted
exec_rd_vld  out  1  exec read data valid pulse
exec_rd_data  out  DATA_WIDTH  exec read data
exec_wr_req  in  1  exec write request; held until granted
exec_wr_addr  in  ADDR_WIDTH  write address
exec_wr_data  in  DATA_WIDTH  write data
exec_wr_gnt  out  1  write accepted (write is complete at the grant edge)
mem_req  out  1  memory access strobe
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rvld  in  1  memory read return valid
mem_rdata  in  DATA_WIDTH  memory read data
proto_err  out  1  sticky: mem_rvld seen with no matching pending read

Behaviour:
- Clock and reset: clk drives all state. reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: all gnt/vld outputs, mem_req, mem_we and proto_err are 0; data/address outputs are 0; the tag pipeline is cleared.
- Grant logic is combinational from the requests. Priority is exec_wr > exec_rd > ifu_rd. Exactly one gnt or none per cycle.
- mem_* outputs are combinational with the grant: mem_req = any gnt, mem_we = exec_wr_gnt, address and data come from the winner.
- A requester holds req, addr and data stable until it sees gnt. Dropping req before gnt is legal and withdraws the request.
- Read grant pushes a tag {valid, src} into a RD_LATENCY-deep shift register; src 0 = ifu, 1 = exec. The tag reaches the head exactly RD_LATENCY cycles after the grant.
- On mem_rvld with a valid head tag: pulse the vld of the tagged source for 1 cycle, with the data set to mem_rdata unregistered. The other source's vld stays 0.
- On mem_rvld with an invalid head tag: drop the data and set proto_err, which holds until reset. A valid head tag with mem_rvld = 0 is also a protocol error: set proto_err and drop the tag.
- Order is in-order, single port. A read granted after a write to the same address returns the new data. Back-to-back reads (one per cycle) are fully pipelined, giving throughput 1/cycle.
- Simultaneous exec_rd_req and exec_wr_req: write wins, read waits at least 1 cycle.
- Reset mid-operation: all pending tags are discarded. No vld is asserted for reads issued before reset. mem_rvld returning after reset is ignored and does NOT set proto_err for RD_LATENCY cycles following reset release.
- No internal buffering of requests; the stall behaviour of exec covers the wait.

Optional Feature:
PDP_ARB_ANTISTARVE_EN
- Defined: a counter tracks consecutive cycles where ifu_rd_req = 1 and is not granted. When it reaches STARVE_LIMIT, the next cycle grants ifu over both exec requests, then the counter clears. The counter also clears on any ifu grant or when ifu_rd_req = 0.
- Undefined: strict fixed priority; no counter logic present.

Test Plan:
- Single fetch: ifu_rd_req = 1, addr = 12'o0200, RD_LATENCY = 2, memory returns 12'o7300 -> ifu_rd_gnt in cycle 0, ifu_rd_vld = 1 with data 12'o7300 in cycle 2, exec_rd_vld = 0 throughout.
- Collision: ifu_rd_req, exec_rd_req and exec_wr_req all asserted in cycle 0 -> grant order exec_wr (c0), exec_rd (c1), ifu (c2); returns: exec_rd_vld at c3, ifu_rd_vld at c4.
- RAW: write 12'o1234 to 12'o0050, then exec read of 12'o0050 next cycle -> exec_rd_data = 12'o1234.
- Pipelined mixed reads: alternate ifu/exec grants for 6 cycles -> 6 vld pulses, each routed to the correct source, in issue order.
- Reset mid-flight: issue a read, assert reset_n = 0 for 1 cycle before the return -> no vld pulse, proto_err stays 0.
- Spurious return: mem_rvld = 1 with an empty tag pipeline -> proto_err = 1 next cycle and stays 1 until reset. With PDP_ARB_ANTISTARVE_EN defined and STARVE_LIMIT = 4: exec_rd_req held continuously with ifu_rd_req = 1 -> ifu granted on the 5th cycle.

Source files
------------

// File: rtl/pdp_mem_arb_if.sv
// pdp_mem_arb_if: request, response and memory-macro signals of the PDP-8 single-port
// memory arbiter, bundled so the arbiter and its surroundings connect through one port.
//
//   Fetch read  : ifu_rd_req/addr in; ifu_rd_gnt, ifu_rd_vld, ifu_rd_data out
//   Exec read   : exec_rd_req/addr in; exec_rd_gnt, exec_rd_vld, exec_rd_data out
//   Exec write  : exec_wr_req/addr/data in; exec_wr_gnt out
//   Memory      : mem_req, mem_we, mem_addr, mem_wdata out; mem_rvld, mem_rdata in
//   Status      : proto_err out (sticky protocol error)
//
// Modports: slave  = the arbiter itself
//           master = requesters plus memory macro (the arbiter's environment)
interface pdp_mem_arb_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic                  ifu_rd_gnt;
    logic                  ifu_rd_vld;
    logic [DATA_WIDTH-1:0] ifu_rd_data;

    logic                  exec_rd_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic                  exec_rd_gnt;
    logic                  exec_rd_vld;
    logic [DATA_WIDTH-1:0] exec_rd_data;

    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;
    logic                  exec_wr_gnt;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvld;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  proto_err;

    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        output ifu_rd_gnt, ifu_rd_vld, ifu_rd_data,
        input  exec_rd_req, exec_rd_addr,
        output exec_rd_gnt, exec_rd_vld, exec_rd_data,
        input  exec_wr_req, exec_wr_addr, exec_wr_data,
        output exec_wr_gnt,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rvld, mem_rdata,
        output proto_err
    );

    modport master (
        output ifu_rd_req, ifu_rd_addr,
        input  ifu_rd_gnt, ifu_rd_vld, ifu_rd_data,
        output exec_rd_req, exec_rd_addr,
        input  exec_rd_gnt, exec_rd_vld, exec_rd_data,
        output exec_wr_req, exec_wr_addr, exec_wr_data,
        input  exec_wr_gnt,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rvld, mem_rdata,
        input  proto_err
    );
endinterface

// File: rtl/pdp_mem_arb.sv
// pdp_mem_arb: arbitrates the PDP-8 fetch port and the exec read/write ports onto one
// pipelined single-port memory macro. At most one request is granted per cycle by fixed
// priority exec_wr > exec_rd > ifu_rd. Granted reads push a {valid, src} tag into a
// RD_LATENCY-deep shift register; the head tag steers mem_rdata back to its requester.
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      pdp_mem_arb_if.slave: requester handshakes, memory macro strobes, proto_err
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH  word address / data width
//   RD_LATENCY              read issue to mem_rvld, in cycles (1..4)
//   STARVE_LIMIT            fetch losses before a forced fetch grant
//
// Build option: define PDP_ARB_ANTISTARVE_EN to add the fetch anti-starvation counter.
// Without it the arbiter is strict fixed priority.
module pdp_mem_arb #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    pdp_mem_arb_if.slave bus
);
    localparam int unsigned IgnW = $clog2(RD_LATENCY + 1);

    if (RD_LATENCY == 0 || RD_LATENCY > 4) begin : g_bad_latency
        $error("pdp_mem_arb: RD_LATENCY must be in 1..4");
    end
    if (STARVE_LIMIT == 0) begin : g_bad_starve
        $error("pdp_mem_arb: STARVE_LIMIT must be at least 1");
    end

    logic                  wr_gnt;
    logic                  rd_gnt;
    logic                  ifu_gnt;
    logic                  force_ifu;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic [DATA_WIDTH-1:0] rdata;

    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_src_q, tag_src_d;
    logic                  head_vld;
    logic                  head_src;
    logic                  ret_ok;
    logic [IgnW-1:0]       ign_q, ign_d;
    logic                  err_q, err_d;

`ifdef PDP_ARB_ANTISTARVE_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_q, starve_d;

    assign force_ifu = bus.ifu_rd_req && (starve_q == StarveW'(STARVE_LIMIT));

    // Counts consecutive cycles the fetch request was present but lost; saturates at
    // the limit so the forced grant fires on the following cycle.
    always_comb begin
        starve_d = starve_q;
        if (!bus.ifu_rd_req || ifu_gnt) begin
            starve_d = '0;
        end else if (starve_q != StarveW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_ifu = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the macro while in reset.
    always_comb begin
        wr_gnt  = 1'b0;
        rd_gnt  = 1'b0;
        ifu_gnt = 1'b0;
        if (reset_n) begin
            if (force_ifu) begin
                ifu_gnt = 1'b1;
            end else if (bus.exec_wr_req) begin
                wr_gnt = 1'b1;
            end else if (bus.exec_rd_req) begin
                rd_gnt = 1'b1;
            end else if (bus.ifu_rd_req) begin
                ifu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (wr_gnt) begin
            addr_mux  = bus.exec_wr_addr;
            wdata_mux = bus.exec_wr_data;
        end else if (rd_gnt) begin
            addr_mux = bus.exec_rd_addr;
        end else if (ifu_gnt) begin
            addr_mux = bus.ifu_rd_addr;
        end
    end

    assign bus.exec_wr_gnt = wr_gnt;
    assign bus.exec_rd_gnt = rd_gnt;
    assign bus.ifu_rd_gnt  = ifu_gnt;
    assign bus.mem_req     = wr_gnt || rd_gnt || ifu_gnt;
    assign bus.mem_we      = wr_gnt;
    assign bus.mem_addr    = addr_mux;
    assign bus.mem_wdata   = wdata_mux;

    // Tag shift register: stage 0 is loaded at the grant edge, the head is the last stage,
    // so a tag is at the head exactly RD_LATENCY cycles after its grant. src 1 = exec.
    always_comb begin
        tag_vld_d    = '0;
        tag_src_d    = '0;
        tag_vld_d[0] = rd_gnt || ifu_gnt;
        tag_src_d[0] = rd_gnt;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_src_d[i] = tag_src_q[i-1];
        end
    end

    assign head_vld = tag_vld_q[RD_LATENCY-1];
    assign head_src = tag_src_q[RD_LATENCY-1];

    always_comb begin
        ign_d = ign_q;
        if (ign_q != '0) begin
            ign_d = ign_q - 1'b1;
        end
        err_d = err_q;
        // Untagged return: tolerated just after reset, when reads issued before it may land.
        if (bus.mem_rvld && !head_vld && (ign_q == '0)) begin
            err_d = 1'b1;
        end
        // Tag at the head with no return: that read is lost; the tag shifts out regardless.
        if (head_vld && !bus.mem_rvld) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_vld_q <= '0;
            tag_src_q <= '0;
            ign_q     <= IgnW'(RD_LATENCY);
            err_q     <= 1'b0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_src_q <= tag_src_d;
            ign_q     <= ign_d;
            err_q     <= err_d;
        end
    end

    // Return data is passed through unregistered; idle data lines are held at zero.
    assign ret_ok            = reset_n && bus.mem_rvld && head_vld;
    assign rdata             = bus.mem_rdata;
    assign bus.ifu_rd_vld    = ret_ok && !head_src;
    assign bus.exec_rd_vld   = ret_ok && head_src;
    assign bus.ifu_rd_data   = bus.ifu_rd_vld ? rdata : '0;
    assign bus.exec_rd_data  = bus.exec_rd_vld ? rdata : '0;
    assign bus.proto_err     = err_q;

endmodule

// File: tb/tb_pdp_mem_arb.sv
// Self-checking bench for pdp_mem_arb. A behavioural single-port memory macro with
// RD_LATENCY read pipeline backs the arbiter; every expected read return is pushed to a
// scoreboard at its grant and checked (source, data, cycle) when a vld pulse appears.
module tb_pdp_mem_arb;
    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 12;
    localparam int unsigned LAT    = 2;
    localparam int unsigned STARVE = 4;

    typedef struct {
        logic          src;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pdp_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pdp_mem_arb #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RD_LATENCY  (LAT),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t sb[$];
    logic [DW-1:0] ref_mem [4096];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        if (a == 12'o0200) return 12'o7300;
        return a ^ 12'o5252;
    endfunction

    // Memory macro model
    logic          mem_init = 1'b1;
    logic          spur_rvld = 1'b0;
    logic          drop_rd = 1'b0;
    logic [DW-1:0] mem [4096];
    logic [LAT-1:0] pv;
    logic [DW-1:0] pd [LAT];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(AW'(i));
            pv <= '0;
            for (int i = 0; i < LAT; i++) pd[i] <= '0;
        end else begin
            if (bus.mem_req && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            pv[0] <= bus.mem_req && !bus.mem_we && !drop_rd;
            pd[0] <= mem[bus.mem_addr];
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign bus.mem_rvld  = pv[LAT-1] | spur_rvld;
    assign bus.mem_rdata = pd[LAT-1];

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t          e;
        logic          gs;
        logic [DW-1:0] gd;
        if (bus.ifu_rd_vld || bus.exec_rd_vld) begin
            tests++;
            if (bus.ifu_rd_vld && bus.exec_rd_vld) begin
                fails++;
                $display("FAIL vld_onehot: cyc %0d both vld high, want one", cyc);
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL vld_unexpected: cyc %0d ifu=%b exec=%b, want no vld",
                         cyc, bus.ifu_rd_vld, bus.exec_rd_vld);
            end else begin
                e  = sb.pop_front();
                gs = bus.exec_rd_vld;
                gd = gs ? bus.exec_rd_data : bus.ifu_rd_data;
                if (gs !== e.src || gd !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL rd_return: got src=%0d data=%o cyc=%0d, want src=%0d data=%o cyc=%0d",
                             gs, gd, cyc, e.src, e.data, e.due);
                end
            end
        end
        if (sb.size() != 0 && cyc > sb[0].due) begin
            tests++;
            fails++;
            $display("FAIL rd_missing: no vld by cyc %0d, want src=%0d data=%o at cyc %0d",
                     cyc, sb[0].src, sb[0].data, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.ifu_rd_req  = 1'b0;
        bus.exec_rd_req = 1'b0;
        bus.exec_wr_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        idle_reqs();
        while (sb.size() != 0 && n < 20) begin
            next_cycle();
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d returns pending, want 0", sb.size());
            sb.delete();
        end
        repeat (2) next_cycle();
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b0) begin
            fails++;
            $display("FAIL proto_err_clean: got %b, want 0", bus.proto_err);
        end
    endtask

    task automatic test_reset();
        bus.ifu_rd_req   = 1'b1;
        bus.ifu_rd_addr  = 12'o0011;
        bus.exec_rd_req  = 1'b1;
        bus.exec_rd_addr = 12'o0022;
        bus.exec_wr_req  = 1'b1;
        bus.exec_wr_addr = 12'o0033;
        bus.exec_wr_data = 12'o4444;
        next_cycle();
        mem_init = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        tests++;
        if ({bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt, bus.mem_req, bus.mem_we} !== 5'b0) begin
            fails++;
            $display("FAIL reset_gnt: got %b, want 00000",
                     {bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt, bus.mem_req, bus.mem_we});
        end
        tests++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            fails++;
            $display("FAIL reset_addr: got addr=%o wdata=%o, want 0 0", bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if ({bus.ifu_rd_vld, bus.exec_rd_vld, bus.proto_err} !== 3'b0 ||
            bus.ifu_rd_data !== '0 || bus.exec_rd_data !== '0) begin
            fails++;
            $display("FAIL reset_out: got vld=%b%b err=%b, want 000",
                     bus.ifu_rd_vld, bus.exec_rd_vld, bus.proto_err);
        end
        next_cycle();
        idle_reqs();
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.mem_req !== 1'b0 || bus.proto_err !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got req=%b err=%b, want 0 0", bus.mem_req, bus.proto_err);
        end
    endtask

    task automatic test_single_fetch();
        next_cycle();
        bus.ifu_rd_req  = 1'b1;
        bus.ifu_rd_addr = 12'o0200;
        @(negedge clk);
        tests++;
        if ({bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt} !== 3'b001) begin
            fails++;
            $display("FAIL fetch_gnt: got %b, want 001",
                     {bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt});
        end
        tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'o0200) begin
            fails++;
            $display("FAIL fetch_mem: got req=%b we=%b addr=%o, want 1 0 0200",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        sb.push_back('{1'b0, 12'o7300, cyc + int'(LAT)});
        next_cycle();
        idle_reqs();
        wait_drain();
    endtask

    task automatic test_collision();
        next_cycle();
        bus.exec_wr_req  = 1'b1;
        bus.exec_wr_addr = 12'o0123;
        bus.exec_wr_data = 12'o4567;
        bus.exec_rd_req  = 1'b1;
        bus.exec_rd_addr = 12'o0300;
        bus.ifu_rd_req   = 1'b1;
        bus.ifu_rd_addr  = 12'o0400;
        @(negedge clk);
        tests++;
        if ({bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt} !== 3'b100 ||
            bus.mem_we !== 1'b1 || bus.mem_addr !== 12'o0123 || bus.mem_wdata !== 12'o4567) begin
            fails++;
            $display("FAIL coll_c0: got gnt=%b we=%b addr=%o wd=%o, want 100 1 0123 4567",
                     {bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt}, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata);
        end
        ref_mem[12'o0123] = 12'o4567;
        next_cycle();
        bus.exec_wr_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt} !== 3'b010 ||
            bus.mem_addr !== 12'o0300) begin
            fails++;
            $display("FAIL coll_c1: got gnt=%b addr=%o, want 010 0300",
                     {bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt}, bus.mem_addr);
        end
        sb.push_back('{1'b1, ref_mem[12'o0300], cyc + int'(LAT)});
        next_cycle();
        bus.exec_rd_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt} !== 3'b001 ||
            bus.mem_addr !== 12'o0400) begin
            fails++;
            $display("FAIL coll_c2: got gnt=%b addr=%o, want 001 0400",
                     {bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt}, bus.mem_addr);
        end
        sb.push_back('{1'b0, ref_mem[12'o0400], cyc + int'(LAT)});
        next_cycle();
        wait_drain();
    endtask

    task automatic test_raw();
        next_cycle();
        bus.exec_wr_req  = 1'b1;
        bus.exec_wr_addr = 12'o0050;
        bus.exec_wr_data = 12'o1234;
        @(negedge clk);
        tests++;
        if (bus.exec_wr_gnt !== 1'b1 || bus.mem_wdata !== 12'o1234) begin
            fails++;
            $display("FAIL raw_wr: got gnt=%b wdata=%o, want 1 1234", bus.exec_wr_gnt, bus.mem_wdata);
        end
        ref_mem[12'o0050] = 12'o1234;
        next_cycle();
        bus.exec_wr_req  = 1'b0;
        bus.exec_rd_req  = 1'b1;
        bus.exec_rd_addr = 12'o0050;
        @(negedge clk);
        tests++;
        if (bus.exec_rd_gnt !== 1'b1) begin
            fails++;
            $display("FAIL raw_rd_gnt: got %b, want 1", bus.exec_rd_gnt);
        end
        sb.push_back('{1'b1, 12'o1234, cyc + int'(LAT)});
        next_cycle();
        wait_drain();
    endtask

    task automatic test_pipelined();
        for (int i = 0; i < 6; i++) begin
            logic          src;
            logic [AW-1:0] a;
            next_cycle();
            src = i[0];
            a   = AW'(12'o1000 + i * 7);
            idle_reqs();
            if (src) begin
                bus.exec_rd_req  = 1'b1;
                bus.exec_rd_addr = a;
            end else begin
                bus.ifu_rd_req  = 1'b1;
                bus.ifu_rd_addr = a;
            end
            @(negedge clk);
            tests++;
            if ({bus.exec_rd_gnt, bus.ifu_rd_gnt} !== {src, ~src} || bus.mem_addr !== a) begin
                fails++;
                $display("FAIL pipe_gnt%0d: got gnt=%b%b addr=%o, want %b%b %o", i,
                         bus.exec_rd_gnt, bus.ifu_rd_gnt, bus.mem_addr, src, ~src, a);
            end
            sb.push_back('{src, ref_mem[a], cyc + int'(LAT)});
        end
        next_cycle();
        wait_drain();
    endtask

    task automatic test_random_priority();
        for (int i = 0; i < 24; i++) begin
            logic [2:0]    r;
            logic [2:0]    want;
            next_cycle();
            r = 3'($urandom_range(0, 7));
            bus.exec_wr_req  = r[2];
            bus.exec_rd_req  = r[1];
            bus.ifu_rd_req   = r[0];
            bus.exec_wr_addr = AW'(12'o2000 + $urandom_range(0, 7));
            bus.exec_wr_data = DW'($urandom_range(0, 4095));
            bus.exec_rd_addr = AW'(12'o2000 + $urandom_range(0, 7));
            bus.ifu_rd_addr  = AW'(12'o2000 + $urandom_range(0, 7));
            want = r[2] ? 3'b100 : (r[1] ? 3'b010 : (r[0] ? 3'b001 : 3'b000));
            @(negedge clk);
            tests++;
            if ({bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt} !== want) begin
                fails++;
                $display("FAIL rand_gnt%0d: got %b, want %b (req %b)", i,
                         {bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt}, want, r);
            end
            if (want[2]) ref_mem[bus.exec_wr_addr] = bus.exec_wr_data;
            if (want[1]) sb.push_back('{1'b1, ref_mem[bus.exec_rd_addr], cyc + int'(LAT)});
            if (want[0]) sb.push_back('{1'b0, ref_mem[bus.ifu_rd_addr], cyc + int'(LAT)});
        end
        next_cycle();
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        next_cycle();
        bus.ifu_rd_req  = 1'b1;
        bus.ifu_rd_addr = 12'o0500;
        @(negedge clk);
        tests++;
        if (bus.ifu_rd_gnt !== 1'b1) begin
            fails++;
            $display("FAIL midrst_gnt: got %b, want 1", bus.ifu_rd_gnt);
        end
        next_cycle();
        idle_reqs();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.ifu_rd_vld !== 1'b0 || bus.exec_rd_vld !== 1'b0) begin
            fails++;
            $display("FAIL midrst_vld: got %b%b, want 00", bus.ifu_rd_vld, bus.exec_rd_vld);
        end
        repeat (3) next_cycle();
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b0) begin
            fails++;
            $display("FAIL midrst_err: got %b, want 0", bus.proto_err);
        end
    endtask

    task automatic test_spurious();
        next_cycle();
        spur_rvld = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b0 || bus.ifu_rd_vld !== 1'b0 || bus.exec_rd_vld !== 1'b0) begin
            fails++;
            $display("FAIL spur_same: got err=%b vld=%b%b, want 0 00", bus.proto_err,
                     bus.ifu_rd_vld, bus.exec_rd_vld);
        end
        next_cycle();
        spur_rvld = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b1) begin
            fails++;
            $display("FAIL spur_set: got %b, want 1", bus.proto_err);
        end
        repeat (3) next_cycle();
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b1) begin
            fails++;
            $display("FAIL spur_sticky: got %b, want 1", bus.proto_err);
        end
        next_cycle();
        do_reset(1);
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b0) begin
            fails++;
            $display("FAIL spur_clear: got %b, want 0", bus.proto_err);
        end
        repeat (LAT + 1) next_cycle();
    endtask

    task automatic test_dropped_return();
        next_cycle();
        bus.exec_rd_req  = 1'b1;
        bus.exec_rd_addr = 12'o0600;
        drop_rd = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.exec_rd_gnt !== 1'b1) begin
            fails++;
            $display("FAIL drop_gnt: got %b, want 1", bus.exec_rd_gnt);
        end
        next_cycle();
        idle_reqs();
        drop_rd = 1'b0;
        next_cycle();
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b0 || bus.exec_rd_vld !== 1'b0) begin
            fails++;
            $display("FAIL drop_head: got err=%b vld=%b, want 0 0", bus.proto_err, bus.exec_rd_vld);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (bus.proto_err !== 1'b1) begin
            fails++;
            $display("FAIL drop_err: got %b, want 1", bus.proto_err);
        end
        next_cycle();
        do_reset(1);
        repeat (LAT + 1) next_cycle();
    endtask

`ifdef PDP_ARB_ANTISTARVE_EN
    task automatic test_antistarve();
        next_cycle();
        bus.exec_rd_req  = 1'b1;
        bus.exec_rd_addr = 12'o0700;
        bus.ifu_rd_req   = 1'b1;
        bus.ifu_rd_addr  = 12'o0710;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] want;
            want = (k == 4) ? 2'b01 : 2'b10;
            @(negedge clk);
            tests++;
            if ({bus.exec_rd_gnt, bus.ifu_rd_gnt} !== want) begin
                fails++;
                $display("FAIL starve_c%0d: got %b%b, want %b", k, bus.exec_rd_gnt,
                         bus.ifu_rd_gnt, want);
            end
            if (want[0]) sb.push_back('{1'b0, ref_mem[12'o0710], cyc + int'(LAT)});
            else         sb.push_back('{1'b1, ref_mem[12'o0700], cyc + int'(LAT)});
            next_cycle();
            if (k == 4) bus.ifu_rd_req = 1'b0;
        end
        wait_drain();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(AW'(i));
        bus.ifu_rd_addr  = '0;
        bus.exec_rd_addr = '0;
        bus.exec_wr_addr = '0;
        bus.exec_wr_data = '0;
        idle_reqs();
        test_reset();
        test_single_fetch();
        test_collision();
        test_raw();
        test_pipelined();
`ifdef PDP_ARB_ANTISTARVE_EN
        test_antistarve();
`else
        test_random_priority();
`endif
        test_reset_midflight();
        test_dropped_return();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
